// File: rtl/op_arb_pkg.sv
// Shared types and constants for the op_unit_arbiter slice.
// Optional statistics are built only when OP_ARB_STATS_EN is defined.
package op_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RESP      = 2'd3
  } arb_state_e;

  localparam int STAT_GRANT_W = 16;
  localparam int STAT_BUSY_W  = 32;

  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Requester slot k positions above ptr, wrapping modulo n.
  function automatic int rr_slot(
    input int ptr,
    input int k,
    input int n
  );
    int s;
    s = ptr + k;
    if (s >= n) s = s - n;
    return s;
  endfunction

endpackage

// File: rtl/op_arb_rr_picker.sv
// Combinational round-robin picker: first valid requester at or
// above rr_ptr, wrapping, as one-hot and encoded index.
module op_arb_rr_picker
  import op_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_any
);

  logic [IDX_W-1:0] slot;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    slot     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = IDX_W'(rr_slot(int'(rr_ptr), k, NUM_REQ));
      if (!pick_any && req_valid[slot]) begin
        pick_any   = 1'b1;
        pick_idx   = slot;
        pick[slot] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/op_unit_arbiter.sv
// Round-robin arbiter in front of one ap_ctrl_hs function unit.
// Grant/busy statistics are built only with OP_ARB_STATS_EN.
module op_unit_arbiter
  import op_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ARG_W   = 72,
  parameter int RES_W   = 32
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*ARG_W-1:0]        req_arg,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [RES_W-1:0]                rsp_data,
  output logic                            fu_ap_start,
  input  logic                            fu_ap_ready,
  input  logic                            fu_ap_done,
  output logic [ARG_W-1:0]                fu_arg,
  input  logic [RES_W-1:0]                fu_ap_return,
  output logic                            err_spurious_done,
  output logic [NUM_REQ*STAT_GRANT_W-1:0] stat_grants,
  output logic [STAT_BUSY_W-1:0]          stat_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);

  if (NUM_REQ < NUM_REQ_MIN || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
    $error("op_unit_arbiter: NUM_REQ out of range");
  end

  arb_state_e state_q, state_d;

  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [ARG_W-1:0] fu_arg_q, fu_arg_d;
  logic [RES_W-1:0] rsp_data_q, rsp_data_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] pick;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;

  logic grant;
  logic take_result;
  logic spurious;

  op_arb_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .pick      (pick),
    .pick_idx  (pick_idx),
    .pick_any  (pick_any)
  );

  assign grant = (state_q == IDLE) && pick_any;

  // Done only counts as a result when the unit has taken its args.
  assign take_result = fu_ap_done &&
                       (((state_q == START) && fu_ap_ready) ||
                        (state_q == WAIT_DONE));

  assign spurious = fu_ap_done &&
                    ((state_q == IDLE) || (state_q == RESP));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      fu_arg_q    <= '0;
      rsp_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      fu_arg_q    <= fu_arg_d;
      rsp_data_q  <= rsp_data_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) state_d = START;
      end
      START: begin
        if (fu_ap_ready && fu_ap_done) state_d = RESP;
        else if (fu_ap_ready)          state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (fu_ap_done) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    grant_idx_d = grant_idx_q;
    fu_arg_d    = fu_arg_q;
    rsp_data_d  = rsp_data_q;
    err_d       = err_q;
    if (grant) begin
      grant_idx_d = pick_idx;
      fu_arg_d    = req_arg[int'(pick_idx)*ARG_W +: ARG_W];
    end
    if (take_result) rsp_data_d = fu_ap_return;
    if (state_q == RESP) begin
      if (grant_idx_q == IDX_W'(NUM_REQ - 1)) rr_ptr_d = '0;
      else                                    rr_ptr_d = grant_idx_q + 1'b1;
    end
    if (spurious) err_d = 1'b1;
  end

  always_comb begin
    fu_ap_start = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    unique case (state_q)
      IDLE:      req_ready = pick;
      START:     fu_ap_start = 1'b1;
      WAIT_DONE: ;
      RESP:      rsp_valid[grant_idx_q] = 1'b1;
      default:   ;
    endcase
  end

  assign fu_arg            = fu_arg_q;
  assign rsp_data          = rsp_data_q;
  assign err_spurious_done = err_q;

`ifdef OP_ARB_STATS_EN
  logic [NUM_REQ*STAT_GRANT_W-1:0] grants_q, grants_d;
  logic [STAT_BUSY_W-1:0]          busy_q, busy_d;

  // Grant counters saturate; the busy counter wraps.
  always_comb begin
    grants_d = grants_q;
    busy_d   = busy_q;
    if (state_q != IDLE) busy_d = busy_q + 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant && (pick_idx == IDX_W'(i)) &&
          (grants_q[i*STAT_GRANT_W +: STAT_GRANT_W] != '1)) begin
        grants_d[i*STAT_GRANT_W +: STAT_GRANT_W] =
          grants_q[i*STAT_GRANT_W +: STAT_GRANT_W] + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      grants_q <= '0;
      busy_q   <= '0;
    end else begin
      grants_q <= grants_d;
      busy_q   <= busy_d;
    end
  end

  assign stat_grants = grants_q;
  assign stat_busy   = busy_q;
`else
  assign stat_grants = '0;
  assign stat_busy   = '0;
`endif

endmodule

// File: tb/tb_op_unit_arbiter.sv
// Scoreboard bench for op_unit_arbiter with a behavioural
// ap_ctrl_hs unit whose ready/done delays are set per test.
module tb_op_unit_arbiter;

  localparam int N  = 4;
  localparam int AW = 72;
  localparam int RW = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_arg;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [RW-1:0]   rsp_data;
  logic            fu_ap_start;
  logic            fu_ap_ready;
  logic            fu_ap_done;
  logic [AW-1:0]   fu_arg;
  logic [RW-1:0]   fu_ap_return;
  logic            err_spurious_done;
  logic [N*16-1:0] stat_grants;
  logic [31:0]     stat_busy;

  op_unit_arbiter #(
    .NUM_REQ (N),
    .ARG_W   (AW),
    .RES_W   (RW)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_arg           (req_arg),
    .req_ready         (req_ready),
    .rsp_valid         (rsp_valid),
    .rsp_data          (rsp_data),
    .fu_ap_start       (fu_ap_start),
    .fu_ap_ready       (fu_ap_ready),
    .fu_ap_done        (fu_ap_done),
    .fu_arg            (fu_arg),
    .fu_ap_return      (fu_ap_return),
    .err_spurious_done (err_spurious_done),
    .stat_grants       (stat_grants),
    .stat_busy         (stat_busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] fmod(input logic [AW-1:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_A5A5;
  endfunction

  // Behavioural function unit.
  int          rdy_dly = 0;
  int          dn_dly  = 0;
  int          st_cnt  = 0;
  int          wd_cnt  = 0;
  bit          waiting = 0;
  logic        m_rdy   = 1'b0;
  logic        m_done  = 1'b0;
  logic [31:0] m_ret   = '0;
  logic [31:0] held    = '0;
  logic        inj_done = 1'b0;
  logic [31:0] inj_ret  = '0;

  assign fu_ap_ready  = m_rdy;
  assign fu_ap_done   = m_done | inj_done;
  assign fu_ap_return = inj_done ? inj_ret : m_ret;

  always begin
    @(posedge clock);
    #2;
    m_rdy  = 1'b0;
    m_done = 1'b0;
    if (reset) begin
      st_cnt  = 0;
      waiting = 0;
    end else if (fu_ap_start) begin
      if (st_cnt == rdy_dly) begin
        m_rdy = 1'b1;
        if (dn_dly == 0) begin
          m_done = 1'b1;
          m_ret  = fmod(fu_arg);
        end else begin
          waiting = 1;
          wd_cnt  = 1;
          held    = fmod(fu_arg);
        end
      end
      st_cnt++;
    end else begin
      st_cnt = 0;
      if (waiting) begin
        if (wd_cnt == dn_dly) begin
          m_done  = 1'b1;
          m_ret   = held;
          waiting = 0;
        end
        wd_cnt++;
      end
    end
  end

  // Scoreboard queues and monitor.
  int          q_g[$];
  int          q_ri[$];
  logic [31:0] q_rd[$];
  int          gt[$];
  int          cyc_no    = 0;
  int          grant_cnt = 0;
  int          overlap   = 0;
  int          me;
  logic [31:0] md;

  always @(posedge clock) cyc_no++;

  always @(negedge clock) begin
    if (fu_ap_start && (req_ready != '0)) overlap++;
    if (req_ready != '0) begin
      grant_cnt++;
      gt.push_back(cyc_no);
      if (q_g.size() == 0) begin
        chk("grant_unexpected", 128'(req_ready), 128'(0));
      end else begin
        me = q_g.pop_front();
        chk("grant_idx", 128'(req_ready), 128'(1) << me);
      end
    end
    if (rsp_valid != '0) begin
      if (q_ri.size() == 0) begin
        chk("rsp_unexpected", 128'(rsp_valid), 128'(0));
      end else begin
        me = q_ri.pop_front();
        md = q_rd.pop_front();
        chk("rsp_vld", 128'(rsp_valid), 128'(1) << me);
        chk("rsp_data", 128'(rsp_data), 128'(md));
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic set_arg(input int i, input logic [AW-1:0] v);
    req_arg[i*AW +: AW] = v;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 200 && q_rd.size() != 0; k++) cyc();
    chk(nm, 128'(q_rd.size()), 128'(0));
  endtask

  task automatic run_grants(input int n);
    int base;
    base = grant_cnt;
    for (int k = 0; k < 300; k++) begin
      cyc();
      if (grant_cnt - base >= n) break;
    end
    req_valid = '0;
    chk("grant_count", 128'(grant_cnt - base), 128'(n));
  endtask

  logic [AW-1:0] a1, a3, a5, a6;
  logic [AW-1:0] a2 [N];
  int            lat;
  bit            found;
  int            exp_g1;
  int            exp_busy;

  initial begin
    req_valid = '0;
    req_arg   = '0;
    a1 = 72'h11_2233_4455_6677_88AB;
    a3 = 72'h0F_1E2D_3C4B_5A69_7887;
    a5 = 72'hAA_BBCC_DDEE_FF00_1122;
    a6 = 72'h33_1357_9BDF_2468_ACE0;
    a2[0] = 72'h01_0000_1000_0000_0010;
    a2[1] = 72'h02_0000_2000_0000_0020;
    a2[2] = 72'h03_0000_3000_0000_0030;
    a2[3] = 72'h04_0000_4000_0000_0040;

    // Reset values.
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #3;
    chk("rst_start", 128'(fu_ap_start), 128'(0));
    chk("rst_ready", 128'(req_ready), 128'(0));
    chk("rst_rsp", 128'(rsp_valid), 128'(0));
    chk("rst_err", 128'(err_spurious_done), 128'(0));
    chk("rst_arg", 128'(fu_arg), 128'(0));
    chk("rst_data", 128'(rsp_data), 128'(0));
    chk("rst_sgr", 128'(stat_grants), 128'(0));
    chk("rst_sbusy", 128'(stat_busy), 128'(0));
    cyc();
    reset = 1'b0;

    // Single request, combinational unit.
    rdy_dly = 0;
    dn_dly  = 0;
    cyc();
    set_arg(2, a1);
    req_valid = 4'b0100;
    q_g.push_back(2);
    q_ri.push_back(2);
    q_rd.push_back(fmod(a1));
    #1 chk("t1_ready", 128'(req_ready), 128'(4'b0100));
    cyc();
    req_valid = '0;
    #1 chk("t1_start", 128'(fu_ap_start), 128'(1));
    chk("t1_arg", 128'(fu_arg), 128'(a1));
    cyc();
    #1 chk("t1_rsp", 128'(rsp_valid), 128'(4'b0100));
    chk("t1_data", 128'(rsp_data), 128'(fmod(a1)));
    cyc();
    #1 chk("t1_idle", 128'(fu_ap_start), 128'(0));

    // All requesters valid, 3-cycle done: rotation 0,1,2,3,0.
    do_reset();
    rdy_dly = 0;
    dn_dly  = 3;
    gt.delete();
    overlap = 0;
    for (int i = 0; i < N; i++) set_arg(i, a2[i]);
    for (int i = 0; i < 5; i++) begin
      q_g.push_back(i % N);
      q_ri.push_back(i % N);
      q_rd.push_back(fmod(a2[i % N]));
    end
    req_valid = 4'hF;
    run_grants(5);
    drain("t2_drain");
    chk("t2_overlap", 128'(overlap), 128'(0));
    chk("t2_ngrants", 128'(gt.size()), 128'(5));
    for (int i = 1; i < gt.size(); i++)
      chk("t2_spacing", 128'(gt[i] - gt[i-1]), 128'(6));

    // Ready delayed 5 cycles, done 2 cycles later; rr_ptr is now 1.
    rdy_dly = 5;
    dn_dly  = 2;
    cyc();
    set_arg(1, a3);
    req_valid = 4'b0010;
    q_g.push_back(1);
    q_ri.push_back(1);
    q_rd.push_back(fmod(a3));
    lat   = 0;
    found = 0;
    for (int k = 1; k <= 40 && !found; k++) begin
      cyc();
      req_valid = '0;
      set_arg(1, '0);
      #1;
      if (k <= 6) begin
        chk("t3_start_hold", 128'(fu_ap_start), 128'(1));
        chk("t3_arg_hold", 128'(fu_arg), 128'(a3));
      end
      if (k == 7) chk("t3_wait_nostart", 128'(fu_ap_start), 128'(0));
      if (rsp_valid != '0) begin
        lat   = k;
        found = 1;
      end
    end
    chk("t3_latency", 128'(lat), 128'(9));

    // Spurious done in IDLE.
    rdy_dly = 0;
    dn_dly  = 0;
    cyc();
    inj_ret  = 32'hDEAD_BEEF;
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    #1 chk("t4_err_set", 128'(err_spurious_done), 128'(1));
    chk("t4_no_rsp", 128'(rsp_valid), 128'(0));
    repeat (3) cyc();
    #1 chk("t4_err_sticky", 128'(err_spurious_done), 128'(1));
    do_reset();
    #1 chk("t4_err_clr", 128'(err_spurious_done), 128'(0));

    // Reset while in WAIT_DONE.
    rdy_dly = 0;
    dn_dly  = 10;
    cyc();
    set_arg(0, a5);
    req_valid = 4'b0001;
    q_g.push_back(0);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    #1 chk("t5_in_wait", 128'(fu_ap_start), 128'(0));
    reset = 1'b1;
    cyc();
    #1 chk("t5_start", 128'(fu_ap_start), 128'(0));
    chk("t5_rsp", 128'(rsp_valid), 128'(0));
    chk("t5_ready", 128'(req_ready), 128'(0));
    chk("t5_arg", 128'(fu_arg), 128'(0));
    chk("t5_data", 128'(rsp_data), 128'(0));
    chk("t5_err", 128'(err_spurious_done), 128'(0));
    cyc();
    reset = 1'b0;
    cyc();
    inj_ret  = 32'h1234_5678;
    inj_done = 1'b1;
    cyc();
    inj_done = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      #1 chk("t5_no_rsp", 128'(rsp_valid), 128'(0));
    end

    // Statistics: 10 grants to req 1, 4 busy cycles each.
    do_reset();
    rdy_dly = 0;
    dn_dly  = 2;
    set_arg(1, a6);
    for (int i = 0; i < 10; i++) begin
      q_g.push_back(1);
      q_ri.push_back(1);
      q_rd.push_back(fmod(a6));
    end
    req_valid = 4'b0010;
    run_grants(10);
    drain("t6_drain");
    repeat (3) cyc();
`ifdef OP_ARB_STATS_EN
    exp_g1   = 10;
    exp_busy = 40;
`else
    exp_g1   = 0;
    exp_busy = 0;
`endif
    #1 chk("t6_grants1", 128'(stat_grants[16 +: 16]), 128'(exp_g1));
    chk("t6_grants0", 128'(stat_grants[0 +: 16]), 128'(0));
    chk("t6_busy", 128'(stat_busy), 128'(exp_busy));

    chk("end_grants_left", 128'(q_g.size()), 128'(0));
    chk("end_rsps_left", 128'(q_ri.size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/op_unit_arbiter.md
# op_unit_arbiter

Round-robin arbiter sharing one ap_ctrl_hs HLS function unit (e.g. the OP_AL_32I ALU core inside the hart) between NUM_REQ requesters. Latches the winner's argument bundle, drives the unit's ap_start/ap_ready/ap_done handshake, and routes the ap_return value back to the winner as a one-cycle response pulse. Sits between hart-level issue logic and the shared unit. Its handshake signals are the ones the dataflow monitor samples.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- ARG_W, default 72: width of the opaque argument bundle per requester.
- RES_W, default 32: width of the function-unit return value.
- clock  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request; held high until matching req_ready.
- req_arg  in  NUM_REQ*ARG_W  requester i owns slice [i*ARG_W +: ARG_W].
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse.
- rsp_valid  out  NUM_REQ  one-hot, one-cycle response pulse.
- rsp_data  out  RES_W  result; valid only while any rsp_valid bit is high.
- fu_ap_start  out  1  ap_ctrl_hs start to the shared unit.
- fu_ap_ready  in  1  unit has consumed its arguments.
- fu_ap_done  in  1  one-cycle completion pulse; fu_ap_return is valid in the same cycle.
- fu_arg  out  ARG_W  registered argument bundle to the unit.
- fu_ap_return  in  RES_W  unit result.
- err_spurious_done  out  1  sticky: fu_ap_done was seen outside START/WAIT_DONE.
- stat_grants  out  NUM_REQ*16  per-requester grant counters (see Configuration).
- stat_busy  out  32  cycles spent with state != IDLE (see Configuration).

## Operation
- FSM states and transitions:
  - IDLE: if any req_valid, pick a winner w and go to START; otherwise stay.
  - START: if fu_ap_ready and fu_ap_done in the same cycle, go to RESP; if fu_ap_ready only, go to WAIT_DONE; otherwise stay.
  - WAIT_DONE: on fu_ap_done, go to RESP.
  - RESP: go to IDLE.
- Winner selection: first requester with req_valid set, scanning upward from rr_ptr with wrap modulo NUM_REQ.
- IDLE with a winner:
  - req_ready[w] is asserted combinationally in that cycle.
  - On the same edge, fu_arg <= req_arg slice w and grant_idx <= w.
- fu_ap_start = 1 exactly while in START. fu_arg is held stable from the grant until fu_ap_ready.
- Result capture: on the fu_ap_done cycle, rsp_data <= fu_ap_return.
- RESP:
  - rsp_valid[grant_idx] = 1.
  - rr_ptr <= (grant_idx+1) mod NUM_REQ; the wrap from NUM_REQ-1 goes to 0.
- No backpressure on responses; the requester must take rsp_data in the pulse cycle.
- A req_valid drop after grant has no effect; the transaction completes.
- Spurious fu_ap_done: ignored for the datapath and sets err_spurious_done. Only reset clears it.

## Timing
- Reset values:
  - state IDLE, rr_ptr 0, grant_idx 0.
  - fu_ap_start, req_ready, rsp_valid, err_spurious_done all 0.
  - fu_arg 0, rsp_data 0, statistics 0.
- Minimum transaction, with a combinational unit (ready and done in the first START cycle): grant in cycle 0, START in cycle 1, RESP in cycle 2. That gives 3 cycles per transaction.
- General latency, grant to rsp_valid: 2 + (cycles START waits for ready) + (cycles WAIT_DONE waits for done).
- No new grant is issued while a transaction is outstanding.
- All requesters valid continuously: grants rotate 0,1,2,3,0...
- Reset mid-transaction: state returns to IDLE on the next edge and no rsp_valid is issued. The shared unit is reset by the same reset.

## Configuration
- Macro: OP_ARB_STATS_EN.
- Defined:
  - stat_grants[i] increments on each grant to requester i and saturates at 0xFFFF.
  - stat_busy increments every non-IDLE cycle and wraps at 2^32.
- Undefined: no counter logic is built and both stat ports are tied to 0. The port list is identical in both builds.

## Structure
- Package op_arb_pkg holds:
  - the state enum (IDLE, START, WAIT_DONE, RESP);
  - the statistics counter widths (16 and 32);
  - the NUM_REQ legal range constants.
- Sub-module op_arb_rr_picker is combinational:
  - inputs: req_valid and rr_ptr;
  - outputs: one-hot pick and encoded index.

## Test plan
- Single request, combinational unit (ready=done=1 in the START cycle), req 2 with arg 0x..AB: req_ready[2] in cycle 0, fu_ap_start in cycle 1, rsp_valid[2] in cycle 2 with rsp_data = fu_ap_return.
- All 4 requesters held valid, unit with 3-cycle done: grant order 0,1,2,3,0. No overlap of fu_ap_start between transactions.
- fu_ap_ready delayed 5 cycles: fu_ap_start and fu_arg hold for 5 cycles, then WAIT_DONE. Latency is 2 + 5 + done delay.
- fu_ap_done pulsed while in IDLE: err_spurious_done=1 and stays set, no rsp_valid. Cleared only by reset.
- Reset asserted in WAIT_DONE: the next cycle has state IDLE and all outputs 0. The later fu_ap_done produces no response.
- OP_ARB_STATS_EN defined, 10 grants to req 1 over 40 busy cycles: stat_grants[1]=10 and stat_busy=40. With the macro undefined, both read 0.
